// File: rtl/bench_responder_mc.sv
// Multi-channel round-trip benchmark engine: per-channel start/send/wait FSMs sharing one
// round-robin arbitrated F2C chunk stream, with per-channel saturating response timers.
//
// state     | meaning
// ST_IDLE   | no run; timer frozen
// ST_SEND   | run started, chunk queued or being streamed
// ST_WAIT   | chunk sent, timing the host response
// ST_DONE   | response seen; timer frozen with the round-trip count
module bench_responder_mc #(
    parameter int NUM_CHAN     = 4,
    parameter int CHUNK_QWORDS = 16,
    parameter int TIMER_WIDTH  = 32,
    parameter int REG_BASE     = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [6:0]  cpuChan_in,
    input  logic [31:0] cpuWrData_in,
    input  logic        cpuWrValid_in,
    input  logic        cpuRdValid_in,
    output logic [31:0] cpuRdData_out,
    output logic        cpuRdValid_out,
    output logic [63:0] f2cData_out,
    output logic        f2cValid_out,
    input  logic        f2cReady_in,
    output logic        f2cLast_out,
    input  logic        c2fCommit_in,
    input  logic [2:0]  c2fTag_in
);

    localparam int CW     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int QW     = $clog2(CHUNK_QWORDS + 1);
    localparam int RESP_W = $clog2(2 * CHUNK_QWORDS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} chan_state_t;

    chan_state_t             state     [NUM_CHAN];
    chan_state_t             state_nxt [NUM_CHAN];
    logic [1:0]              mode      [NUM_CHAN];
    logic [TIMER_WIDTH-1:0]  timer     [NUM_CHAN];
    logic [23:0]             run_cnt   [NUM_CHAN];
    logic [RESP_W-1:0]       resp_cnt  [NUM_CHAN];
    logic [NUM_CHAN-1:0]     start;
    logic [NUM_CHAN-1:0]     resp_inc;

    logic          gnt_active;
    logic [CW-1:0] gnt_chan;
    logic [CW-1:0] arb_ptr;
    logic [QW-1:0] qword_idx;
    logic          pick_found;
    logic [CW-1:0] pick_chan;
    logic [CW-1:0] pick_idx;
    int            pick_j;

    logic          abort;
    logic          handshake;
    logic          last_beat;
    logic          chunk_done;
    logic [31:0]   status_word;
    logic [31:0]   rd_mux;
    logic          unused_wr_bits;

    assign abort          = cpuWrValid_in && (cpuChan_in == 7'(REG_BASE)) && cpuWrData_in[0];
    assign handshake      = gnt_active && f2cReady_in;
    assign last_beat      = (qword_idx == QW'(CHUNK_QWORDS - 1));
    assign chunk_done     = handshake && last_beat;
    assign unused_wr_bits = ^cpuWrData_in[31:2];

    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            state_nxt[c] = state[c];
            start[c]     = 1'b0;
            resp_inc[c]  = 1'b0;
            if (abort) begin
                state_nxt[c] = ST_IDLE;
            end else begin
                case (state[c])
                    ST_IDLE, ST_DONE: begin
                        if (cpuWrValid_in && cpuChan_in == 7'(REG_BASE + 1 + c)) begin
                            start[c]     = 1'b1;
                            state_nxt[c] = ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (chunk_done && gnt_chan == CW'(c)) state_nxt[c] = ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (mode[c] == 2'd0) begin
                            if (c2fCommit_in && c2fTag_in == 3'(c)) state_nxt[c] = ST_DONE;
                        end else if (cpuWrValid_in && cpuChan_in == 7'(REG_BASE + 1 + c)) begin
                            // register mode completes on the final response write, single-reg on the first
                            if (mode[c] == 2'd1) begin
                                resp_inc[c] = 1'b1;
                                if (resp_cnt[c] == RESP_W'(2 * CHUNK_QWORDS - 1)) state_nxt[c] = ST_DONE;
                            end else begin
                                state_nxt[c] = ST_DONE;
                            end
                        end
                    end
                    default: state_nxt[c] = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (reset_in) state[c] <= ST_IDLE;
            else          state[c] <= state_nxt[c];
        end
    end

    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (reset_in) begin
                mode[c]     <= 2'd0;
                timer[c]    <= '0;
                run_cnt[c]  <= '0;
                resp_cnt[c] <= '0;
            end else if (start[c]) begin
                mode[c]     <= cpuWrData_in[1:0];
                timer[c]    <= '0;
                run_cnt[c]  <= run_cnt[c] + 24'd1;
                resp_cnt[c] <= '0;
            end else begin
                if ((state[c] == ST_SEND || state[c] == ST_WAIT) && timer[c] != '1)
                    timer[c] <= timer[c] + 1'b1;
                if (resp_inc[c]) resp_cnt[c] <= resp_cnt[c] + 1'b1;
            end
        end
    end

    // Search starts one past the most recently granted channel.
    always_comb begin
        pick_found = 1'b0;
        pick_chan  = '0;
        pick_idx   = '0;
        pick_j     = 0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            pick_j = int'(arb_ptr) + i;
            if (pick_j >= NUM_CHAN) pick_j = pick_j - NUM_CHAN;
            pick_idx = CW'(pick_j);
            if (!pick_found && state[pick_idx] == ST_SEND) begin
                pick_found = 1'b1;
                pick_chan  = pick_idx;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            gnt_active <= 1'b0;
            gnt_chan   <= '0;
            arb_ptr    <= '0;
            qword_idx  <= '0;
        end else if (abort) begin
            gnt_active <= 1'b0;
            qword_idx  <= '0;
        end else if (gnt_active) begin
            if (handshake) begin
                if (last_beat) begin
                    gnt_active <= 1'b0;
                    qword_idx  <= '0;
                end else begin
                    qword_idx <= qword_idx + 1'b1;
                end
            end
        end else if (pick_found) begin
            gnt_active <= 1'b1;
            gnt_chan   <= pick_chan;
            qword_idx  <= '0;
            arb_ptr    <= (pick_chan == CW'(NUM_CHAN - 1)) ? '0 : pick_chan + 1'b1;
        end
    end

    assign f2cValid_out = gnt_active;
    assign f2cLast_out  = gnt_active && last_beat;
    assign f2cData_out  = {8'(gnt_chan), run_cnt[gnt_chan], 32'(qword_idx)};

    always_comb begin
        status_word = '0;
        rd_mux      = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            status_word[c]     = (state[c] == ST_SEND) || (state[c] == ST_WAIT);
            status_word[8 + c] = (state[c] == ST_DONE);
        end
        if (cpuChan_in == 7'(REG_BASE)) rd_mux = status_word;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (cpuChan_in == 7'(REG_BASE + 1 + c)) rd_mux = 32'(timer[c]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cpuRdValid_out <= 1'b0;
            cpuRdData_out  <= '0;
        end else begin
            cpuRdValid_out <= cpuRdValid_in;
            cpuRdData_out  <= cpuRdValid_in ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_bench_responder_mc.sv
// Directed-plus-random bench for bench_responder_mc: a wide-timer and an 8-bit-timer instance
// share stimulus; expectations come from an elapsed-cycle / run-count model of each channel.
module tb_bench_responder_mc;

    localparam int NC = 4;
    localparam int CQ = 16;
    localparam int RB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  chan;
    logic [31:0] wdata;
    logic        wvalid, rvalid, ready, commit;
    logic [2:0]  tag;

    logic [31:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid;
    logic [63:0] a_data, b_data;
    logic        a_valid, b_valid, a_last, b_last;

    always #5 clk = ~clk;

    bench_responder_mc #(.NUM_CHAN(NC), .CHUNK_QWORDS(CQ), .TIMER_WIDTH(32), .REG_BASE(RB)) dut_a (
        .clk_in(clk), .reset_in(rst), .cpuChan_in(chan), .cpuWrData_in(wdata),
        .cpuWrValid_in(wvalid), .cpuRdValid_in(rvalid), .cpuRdData_out(a_rdata),
        .cpuRdValid_out(a_rvalid), .f2cData_out(a_data), .f2cValid_out(a_valid),
        .f2cReady_in(ready), .f2cLast_out(a_last), .c2fCommit_in(commit), .c2fTag_in(tag));

    bench_responder_mc #(.NUM_CHAN(NC), .CHUNK_QWORDS(CQ), .TIMER_WIDTH(8), .REG_BASE(RB)) dut_b (
        .clk_in(clk), .reset_in(rst), .cpuChan_in(chan), .cpuWrData_in(wdata),
        .cpuWrValid_in(wvalid), .cpuRdValid_in(rvalid), .cpuRdData_out(b_rdata),
        .cpuRdValid_out(b_rvalid), .f2cData_out(b_data), .f2cValid_out(b_valid),
        .f2cReady_in(ready), .f2cLast_out(b_last), .c2fCommit_in(commit), .c2fTag_in(tag));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: 0 idle, 1 busy, 2 done
    int m_state [NC];
    int m_start [NC];
    int m_end   [NC];
    int m_run   [NC];
    int last_gnt;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // F2C monitor samples on the falling edge, i.e. what the next rising edge will see.
    logic [63:0] cap_d [$];
    logic        cap_l [$];
    int          hs_total = 0;
    bit          allow_drop = 0;
    bit          stalled = 0;
    logic [63:0] st_data;
    logic        st_last;

    always @(negedge clk) begin
        if (stalled && !allow_drop) begin
            chk("stall_valid", 64'(a_valid), 64'd1);
            chk("stall_data", a_data, st_data);
            chk("stall_last", 64'(a_last), 64'(st_last));
        end
        stalled = (a_valid === 1'b1) && (ready === 1'b0);
        st_data = a_data;
        st_last = a_last;
        if (a_valid === 1'b1 && ready === 1'b1) begin
            cap_d.push_back(a_data);
            cap_l.push_back(a_last);
            hs_total++;
        end
    end

    function automatic longint exp_timer(int c, int r, int w);
        longint v;
        longint mx;
        mx = (64'd1 << w) - 1;
        if (m_state[c] == 1) v = longint'(r - 1 - m_start[c]);
        else                 v = longint'(m_end[c] - m_start[c]);
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint exp_reg(int ch, int r, int w);
        longint s;
        s = 0;
        if (ch == RB) begin
            for (int c = 0; c < NC; c++) begin
                if (m_state[c] == 1) s = s | (64'd1 << c);
                if (m_state[c] == 2) s = s | (64'd1 << (8 + c));
            end
        end else if (ch > RB && ch <= RB + NC) begin
            s = exp_timer(ch - RB - 1, r, w);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [31:0] d);
        chan = 7'(ch); wdata = d; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
    endtask

    task automatic start(input int c, input int md);
        logic [31:0] d;
        d = $urandom();
        d[1:0] = 2'(md);
        wr(RB + 1 + c, d);
        m_state[c] = 1;
        m_start[c] = cyc;
        m_run[c]   = (m_run[c] + 1) & 32'h00FF_FFFF;
    endtask

    task automatic finish_run(input int c);
        m_state[c] = 2;
        m_end[c]   = cyc;
    endtask

    task automatic model_abort();
        for (int c = 0; c < NC; c++) begin
            if (m_state[c] == 1) m_end[c] = cyc;
            m_state[c] = 0;
        end
    endtask

    task automatic rd_chk(input int ch, input string name);
        chan = 7'(ch); rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        chk({name, "_rv"}, 64'(a_rvalid), 64'd1);
        chk({name, "_a"}, 64'(a_rdata), exp_reg(ch, cyc, 32));
        chk({name, "_b"}, 64'(b_rdata), exp_reg(ch, cyc, 8));
    endtask

    function automatic int next_rr(input bit pend [NC]);
        int c;
        for (int i = 1; i <= NC; i++) begin
            c = (last_gnt + i) % NC;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic get_chunk(input int c, input bit rnd);
        int budget;
        logic [63:0] d;
        logic        l;
        logic [63:0] e;
        budget = 0;
        while (cap_d.size() < CQ && budget < 400) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            budget++;
        end
        chk("chunk_complete", 64'(cap_d.size() >= CQ), 64'd1);
        for (int k = 0; k < CQ; k++) begin
            if (cap_d.size() > 0) begin
                d = cap_d.pop_front();
                l = cap_l.pop_front();
                e = {8'(c), 24'(m_run[c]), 32'(k)};
                chk("chunk_data", d, e);
                chk("chunk_last", 64'(l), 64'(k == CQ - 1));
            end
        end
        last_gnt = c;
    endtask

    initial begin
        int t0, n, budget, hs0, ec;
        bit pend [NC];
        rst = 1'b1; chan = '0; wdata = '0; wvalid = 1'b0; rvalid = 1'b0;
        ready = 1'b0; commit = 1'b0; tag = '0;
        for (int c = 0; c < NC; c++) begin
            m_state[c] = 0; m_start[c] = 0; m_end[c] = 0; m_run[c] = 0;
        end
        last_gnt = NC - 1;
        repeat (3) tick();
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_last", 64'(a_last), 64'd0);
        chk("rst_rvalid", 64'(a_rvalid), 64'd0);
        chk("rst_rdata", 64'(a_rdata), 64'd0);
        chk("rst_b_rdata", 64'(b_rdata), 64'd0);
        rst = 1'b0;
        tick();
        rd_chk(RB, "rst_status");
        rd_chk(RB + 1, "rst_timer0");
        tick();
        chk("rd_pulse_end", 64'(a_rvalid), 64'd0);

        // s-mode on ch0; a write while still in SEND must not complete the run
        start(0, 2);
        t0 = cyc;
        wr(RB + 1, $urandom());
        get_chunk(0, 1'b0);
        n = $urandom_range(30, 60);
        while (cyc < t0 + n - 1) tick();
        wr(RB + 1, $urandom());
        finish_run(0);
        rd_chk(RB + 1, "s_timer");
        rd_chk(RB, "s_status");

        // r-mode on ch1
        start(1, 1);
        get_chunk(1, 1'b0);
        for (int i = 0; i < 2 * CQ - 1; i++) begin
            wr(RB + 2, $urandom());
            if ($urandom_range(0, 1) == 1) tick();
        end
        rd_chk(RB, "r_status_31");
        rd_chk(RB + 2, "r_timer_live");
        wr(RB + 2, $urandom());
        finish_run(1);
        rd_chk(RB + 2, "r_timer");
        rd_chk(RB, "r_status");

        // q-mode on ch2
        start(2, 0);
        get_chunk(2, 1'b1);
        commit = 1'b1; tag = 3'd3; tick();
        tag = 3'd5; tick();
        tag = 3'd0; tick();
        commit = 1'b0;
        wr(RB + 3, $urandom());
        wr(RB + 3, $urandom());
        rd_chk(RB, "q_status_wait");
        rd_chk(RB + 1, "q_ch0_frozen");
        commit = 1'b1; tag = 3'd2; tick();
        commit = 1'b0;
        finish_run(2);
        rd_chk(RB + 3, "q_timer");
        rd_chk(RB, "q_status");

        // saturation on ch3, mode 3 behaves as single-reg
        start(3, 3);
        t0 = cyc;
        get_chunk(3, 1'b0);
        rd_chk(RB + 4, "sat_live");
        while (cyc < t0 + 299) tick();
        wr(RB + 4, $urandom());
        finish_run(3);
        rd_chk(RB + 4, "sat_timer");

        // arbitration under random backpressure
        ready = 1'b0;
        hs0 = hs_total;
        for (int c = 0; c < NC; c++) begin
            start(c, 2);
            pend[c] = 1'b1;
        end
        for (int i = 0; i < NC; i++) begin
            ec = next_rr(pend);
            if (ec >= 0) begin
                get_chunk(ec, 1'b1);
                pend[ec] = 1'b0;
            end
        end
        ready = 1'b1;
        chk("arb_handshakes", 64'(hs_total - hs0), 64'(NC * CQ));
        rd_chk(RB, "arb_status");

        // STATUS write with bit0 clear is harmless, with bit0 set aborts
        wr(RB, $urandom() & 32'hFFFF_FFFE);
        rd_chk(RB, "noabort_status");
        wr(RB, $urandom() | 32'h1);
        model_abort();
        rd_chk(RB, "abort_status");
        rd_chk(RB + 1, "abort_timer_kept");

        // abort mid-chunk
        cap_d.delete(); cap_l.delete();
        start(1, 2);
        budget = 0;
        while (cap_d.size() < 6 && budget < 100) begin ready = 1'b1; tick(); budget++; end
        ready = 1'b0;
        chk("abort_partial", 64'(cap_d.size()), 64'd6);
        allow_drop = 1'b1;
        wr(RB, 32'h1);
        model_abort();
        last_gnt = 1;
        chk("abort_drop", 64'(a_valid), 64'd0);
        tick();
        allow_drop = 1'b0;
        rd_chk(RB, "abort_idle");
        cap_d.delete(); cap_l.delete();
        start(1, 2);
        get_chunk(1, 1'b0);

        // reset mid-chunk
        cap_d.delete(); cap_l.delete();
        start(2, 2);
        budget = 0;
        while (cap_d.size() < 6 && budget < 100) begin ready = 1'b1; tick(); budget++; end
        ready = 1'b0;
        allow_drop = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < NC; c++) begin
            m_state[c] = 0; m_start[c] = 0; m_end[c] = 0; m_run[c] = 0;
        end
        last_gnt = NC - 1;
        chk("reset_drop", 64'(a_valid), 64'd0);
        tick();
        allow_drop = 1'b0;
        rd_chk(RB + 3, "reset_timer");
        rd_chk(RB, "reset_status");
        cap_d.delete(); cap_l.delete();
        start(2, 2);
        get_chunk(2, 1'b1);
        ready = 1'b1;

        // unmapped accesses, then back-to-back reads
        wr(RB + NC + 1, 32'h2);
        rd_chk(RB - 1, "unmapped_lo");
        rd_chk(RB + NC + 1, "unmapped_hi");
        rd_chk(127, "unmapped_top");
        rd_chk(RB, "unmapped_wr_status");
        rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chan = (i == 1) ? 7'(RB) : 7'(RB + 3);
            tick();
            chk("b2b_rv", 64'(a_rvalid), 64'd1);
            chk("b2b_data", 64'(a_rdata), exp_reg(int'(chan), cyc, 32));
        end
        rvalid = 1'b0;
        tick();
        chk("b2b_end", 64'(a_rvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
